// File: rtl/uart_pkg.sv
// Shared definitions for the UART frame transmitter: parity encodings,
// FSM state type and payload width.
package uart_pkg;

  localparam int DATA_W = 8;

  localparam logic [1:0] PAR_ODD  = 2'b01;
  localparam logic [1:0] PAR_EVEN = 2'b10;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } state_e;

  // A parity slot exists only for the two explicit encodings; 00 and 11 mean none.
  function automatic logic parity_enabled(input logic [1:0] ptype);
    return (ptype == PAR_ODD) || (ptype == PAR_EVEN);
  endfunction

endpackage

// File: rtl/uart_tx_frame_if.sv
// Request/response bundle between a frame producer (master) and the
// transmitter (slave).
interface uart_tx_frame_if;
  import uart_pkg::*;

  logic              send;
  logic [DATA_W-1:0] data_in;
  logic [1:0]        parity_type;
  logic              parity_bit;
  logic              stop_bits;
  logic              data_tx;
  logic              busy;
  logic              done_flag;

  modport master (
    output send, data_in, parity_type, parity_bit, stop_bits,
    input  data_tx, busy, done_flag
  );

  modport slave (
    input  send, data_in, parity_type, parity_bit, stop_bits,
    output data_tx, busy, done_flag
  );

endinterface

// File: rtl/uart_baud_cnt.sv
// Bit-period counter: runs 0..CLKS_PER_BIT-1 and flags the last cycle of
// each period; clear holds it at zero.
module uart_baud_cnt #(
  parameter int CLKS_PER_BIT = 5208
) (
  input  logic clock,
  input  logic reset,
  input  logic clear,
  output logic tick
);

  localparam logic [15:0] LAST_CNT = 16'(CLKS_PER_BIT - 1);

  logic [15:0] cnt_q;
  logic [15:0] cnt_d;

  // Next count: wrap at the end of each period, pinned to zero while cleared.
  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = 16'd0;
    end else if (cnt_q == LAST_CNT) begin
      cnt_d = 16'd0;
    end else begin
      cnt_d = cnt_q + 16'd1;
    end
  end

  // Counter register.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cnt_q <= 16'd0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tick = (cnt_q == LAST_CNT);

endmodule

// File: rtl/uart_tx_frame.sv
// UART frame transmitter: start bit, 8 data bits LSB first, optional
// externally supplied parity bit, one or two stop bits.
module uart_tx_frame
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 5208
) (
  input  logic            clock,
  input  logic            reset,
  uart_tx_frame_if.slave  bus
);

  state_e            state_q,   state_d;
  logic [2:0]        bit_idx_q, bit_idx_d;
  logic              stop_idx_q, stop_idx_d;
  logic [DATA_W-1:0] data_q,    data_d;
  logic [1:0]        ptype_q,   ptype_d;
  logic              pbit_q,    pbit_d;
  logic              stop2_q,   stop2_d;
  logic              data_tx_q, data_tx_d;
  logic              busy_q,    busy_d;
  logic              done_q,    done_d;

  logic              tick_s;
  logic              clear_s;
  logic [2:0]        nxt_idx_s;

  // The counter only runs inside a frame, so it is already zero on accept.
  assign clear_s   = (state_q == ST_IDLE);
  assign nxt_idx_s = bit_idx_q + 3'd1;

  uart_baud_cnt #(
    .CLKS_PER_BIT (CLKS_PER_BIT)
  ) u_baud (
    .clock (clock),
    .reset (reset),
    .clear (clear_s),
    .tick  (tick_s)
  );

  // Next-state and next-output logic; the line value is computed one edge
  // ahead so data_tx comes straight from a flop.
  always_comb begin
    state_d    = state_q;
    bit_idx_d  = bit_idx_q;
    stop_idx_d = stop_idx_q;
    data_d     = data_q;
    ptype_d    = ptype_q;
    pbit_d     = pbit_q;
    stop2_d    = stop2_q;
    data_tx_d  = data_tx_q;
    busy_d     = busy_q;
    done_d     = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (bus.send) begin
          state_d    = ST_START;
          data_d     = bus.data_in;
          ptype_d    = bus.parity_type;
          pbit_d     = bus.parity_bit;
          stop2_d    = bus.stop_bits;
          bit_idx_d  = 3'd0;
          stop_idx_d = 1'b0;
          data_tx_d  = 1'b0;
          busy_d     = 1'b1;
        end else begin
          data_tx_d  = 1'b1;
          busy_d     = 1'b0;
        end
      end

      ST_START: begin
        if (tick_s) begin
          state_d   = ST_DATA;
          bit_idx_d = 3'd0;
          data_tx_d = data_q[0];
        end else begin
          state_d   = ST_START;
        end
      end

      ST_DATA: begin
        if (tick_s) begin
          if (bit_idx_q == 3'd7) begin
            if (parity_enabled(ptype_q)) begin
              state_d    = ST_PARITY;
              data_tx_d  = pbit_q;
            end else begin
              state_d    = ST_STOP;
              stop_idx_d = 1'b0;
              data_tx_d  = 1'b1;
            end
          end else begin
            bit_idx_d = nxt_idx_s;
            data_tx_d = data_q[nxt_idx_s];
          end
        end else begin
          state_d = ST_DATA;
        end
      end

      ST_PARITY: begin
        if (tick_s) begin
          state_d    = ST_STOP;
          stop_idx_d = 1'b0;
          data_tx_d  = 1'b1;
        end else begin
          state_d    = ST_PARITY;
        end
      end

      ST_STOP: begin
        if (tick_s) begin
          if (stop2_q && !stop_idx_q) begin
            stop_idx_d = 1'b1;
          end else begin
            state_d    = ST_IDLE;
            busy_d     = 1'b0;
            done_d     = 1'b1;
            data_tx_d  = 1'b1;
          end
        end else begin
          state_d = ST_STOP;
        end
      end

      default: begin
        state_d   = ST_IDLE;
        data_tx_d = 1'b1;
        busy_d    = 1'b0;
      end
    endcase
  end

  // State, capture and output registers; reset drives the line high at once.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q    <= ST_IDLE;
      bit_idx_q  <= 3'd0;
      stop_idx_q <= 1'b0;
      data_q     <= '0;
      ptype_q    <= 2'b00;
      pbit_q     <= 1'b0;
      stop2_q    <= 1'b0;
      data_tx_q  <= 1'b1;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      bit_idx_q  <= bit_idx_d;
      stop_idx_q <= stop_idx_d;
      data_q     <= data_d;
      ptype_q    <= ptype_d;
      pbit_q     <= pbit_d;
      stop2_q    <= stop2_d;
      data_tx_q  <= data_tx_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  assign bus.data_tx   = data_tx_q;
  assign bus.busy      = busy_q;
  assign bus.done_flag = done_q;

endmodule

// File: tb/tb_uart_tx_frame.sv
// Directed, table-driven bench for uart_tx_frame with a 4-cycle bit period.
module tb_uart_tx_frame;

  localparam int CPB = 4;

  typedef struct {
    logic [7:0]  data;
    logic [1:0]  ptype;
    logic        pbit;
    logic        stop2;
    int          nbits;
    logic [11:0] seq;   // expected line bits in send order, MSB first
  } vec_t;

  logic clock;
  logic reset;
  int   pass_cnt;
  int   total_cnt;
  vec_t vecs [5];

  uart_tx_frame_if bus ();

  uart_tx_frame #(
    .CLKS_PER_BIT (CPB)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) begin
      pass_cnt++;
    end else begin
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Sends one frame, scrambles the inputs after accept, optionally issues a
  // send mid-frame, and checks every cycle plus the completion pulse.
  task automatic run_frame(input vec_t v, input bit inject);
    @(negedge clock);
    bus.data_in     = v.data;
    bus.parity_type = v.ptype;
    bus.parity_bit  = v.pbit;
    bus.stop_bits   = v.stop2;
    bus.send        = 1'b1;
    @(negedge clock);
    bus.send        = 1'b0;
    bus.data_in     = ~v.data;
    bus.parity_type = ~v.ptype;
    bus.parity_bit  = ~v.pbit;
    bus.stop_bits   = ~v.stop2;
    for (int i = 0; i < v.nbits * CPB; i++) begin
      if (inject && i == 10) begin
        bus.send    = 1'b1;
        bus.data_in = 8'h00;
      end else begin
        bus.send    = 1'b0;
      end
      check("frame_tx", {31'd0, bus.data_tx}, {31'd0, v.seq[11 - (i / CPB)]});
      check("frame_busy", {31'd0, bus.busy}, 32'd1);
      check("frame_done_low", {31'd0, bus.done_flag}, 32'd0);
      @(negedge clock);
    end
    bus.send = 1'b0;
    check("done_pulse", {31'd0, bus.done_flag}, 32'd1);
    check("busy_end", {31'd0, bus.busy}, 32'd0);
    check("tx_idle_end", {31'd0, bus.data_tx}, 32'd1);
    @(negedge clock);
    check("done_once", {31'd0, bus.done_flag}, 32'd0);
    check("stay_idle", {31'd0, bus.data_tx}, 32'd1);
  endtask

  initial begin
    int d1;
    int d2;
    pass_cnt  = 0;
    total_cnt = 0;

    vecs[0] = '{data: 8'h55, ptype: 2'b10, pbit: 1'b0, stop2: 1'b0, nbits: 11, seq: 12'b0101_0101_0010};
    vecs[1] = '{data: 8'hA5, ptype: 2'b01, pbit: 1'b1, stop2: 1'b1, nbits: 12, seq: 12'b0101_0010_1111};
    vecs[2] = '{data: 8'hFF, ptype: 2'b00, pbit: 1'b0, stop2: 1'b0, nbits: 10, seq: 12'b0111_1111_1100};
    vecs[3] = '{data: 8'h3C, ptype: 2'b11, pbit: 1'b1, stop2: 1'b1, nbits: 11, seq: 12'b0001_1110_0110};
    vecs[4] = '{data: 8'h01, ptype: 2'b10, pbit: 1'b1, stop2: 1'b0, nbits: 11, seq: 12'b0100_0000_0110};

    reset           = 1'b0;
    bus.send        = 1'b0;
    bus.data_in     = 8'h00;
    bus.parity_type = 2'b00;
    bus.parity_bit  = 1'b0;
    bus.stop_bits   = 1'b0;
    repeat (3) @(negedge clock);
    check("rst_tx", {31'd0, bus.data_tx}, 32'd1);
    check("rst_busy", {31'd0, bus.busy}, 32'd0);
    check("rst_done", {31'd0, bus.done_flag}, 32'd0);
    reset = 1'b1;

    for (int k = 0; k < 5; k++) begin
      run_frame(vecs[k], 1'b0);
    end

    // Send while busy must be ignored.
    run_frame(vecs[0], 1'b1);

    // Reset during data bit 3 of a 0x55 frame.
    @(negedge clock);
    bus.data_in     = 8'h55;
    bus.parity_type = 2'b10;
    bus.parity_bit  = 1'b0;
    bus.stop_bits   = 1'b0;
    bus.send        = 1'b1;
    @(negedge clock);
    bus.send = 1'b0;
    repeat (17) @(negedge clock);
    check("pre_reset_busy", {31'd0, bus.busy}, 32'd1);
    check("pre_reset_tx", {31'd0, bus.data_tx}, 32'd0);
    #2 reset = 1'b0;
    #1;
    check("async_rst_tx", {31'd0, bus.data_tx}, 32'd1);
    check("async_rst_busy", {31'd0, bus.busy}, 32'd0);
    for (int c = 0; c < 3; c++) begin
      @(negedge clock);
      check("rst_no_done", {31'd0, bus.done_flag}, 32'd0);
    end
    reset = 1'b1;
    run_frame(vecs[0], 1'b0);

    // Back-to-back frames with send held high.
    @(negedge clock);
    bus.data_in     = 8'h01;
    bus.parity_type = 2'b10;
    bus.parity_bit  = 1'b1;
    bus.stop_bits   = 1'b0;
    bus.send        = 1'b1;
    d1 = -1;
    d2 = -1;
    for (int c = 0; c < 200 && d2 < 0; c++) begin
      @(negedge clock);
      if (d1 >= 0 && c == d1 + 1) begin
        check("b2b_restart_low", {31'd0, bus.data_tx}, 32'd0);
      end
      if (bus.done_flag) begin
        if (d1 < 0) begin
          d1 = c;
          check("b2b_gap_high", {31'd0, bus.data_tx}, 32'd1);
        end else begin
          d2 = c;
          bus.send = 1'b0;
        end
      end
    end
    bus.send = 1'b0;
    check("b2b_first_done", d1, 32'd44);
    check("b2b_second_seen", {31'd0, d2 >= 0}, 32'd1);
    check("b2b_spacing", d2 - d1, 32'd45);
    repeat (3) @(negedge clock);
    check("b2b_idle_after", {31'd0, bus.busy}, 32'd0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
